// File: rtl/bram_block_sum_ctrl.sv
// Framed block-sum controller around an 8x8 single-port BRAM.
// Loads one block from a byte stream, reads it back, emits the block sum.
module bram_block_sum_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     bram_we,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic [DATA_W-1:0]        bram_din,
    input  logic [DATA_W-1:0]        bram_dout,
    output logic [DATA_W+ADDR_W-1:0] sum_out,
    output logic                     sum_valid,
    output logic                     busy
);

    localparam int SUM_W = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {LOAD, READ, DRAIN, DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]   rcnt_q, rcnt_d;
    logic [SUM_W-1:0]    acc_q, acc_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [RD_LAT-1:0]   vld_q, vld_d;
    logic [1:0]          dcnt_q, dcnt_d;
    logic                issue;
    logic                beat;
    logic [SUM_W-1:0]    acc_add;

    assign beat    = vld_q[RD_LAT-1];
    assign acc_add = acc_q + {{ADDR_W{1'b0}}, bram_dout};
    assign sum_out = sum_q;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        acc_d     = beat ? acc_add : acc_q;
        sum_d     = sum_q;
        dcnt_d    = dcnt_q;
        issue     = 1'b0;
        in_ready  = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = in_data;
        sum_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            LOAD: begin
                busy      = 1'b0;
                in_ready  = 1'b1;
                bram_addr = wcnt_q;
                bram_we   = in_valid;
                if (in_valid) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LAST) begin
                        wcnt_d  = '0;
                        acc_d   = '0;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                bram_addr = rcnt_q;
                issue     = 1'b1;
                rcnt_d    = rcnt_q + 1'b1;
                if (rcnt_q == LAST) begin
                    rcnt_d  = '0;
                    dcnt_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + 1'b1;
                // acc_d already includes the final in-flight beat
                if (dcnt_q == 2'(RD_LAT - 1)) begin
                    sum_d   = acc_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                sum_valid = 1'b1;
                state_d   = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            vld_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            vld_q   <= vld_d;
            dcnt_q  <= dcnt_d;
        end
    end

endmodule
